// File: rtl/sobel_pkg.sv
// Shared constants and types for the Sobel pipeline stages.
package sobel_pkg;

  localparam int unsigned PIX_W     = 8;
  localparam int unsigned ADDR_W    = 20;
  localparam int unsigned DIM_W     = 10;
  localparam int unsigned DIM_X_W   = DIM_W + 1;
  localparam int unsigned WIN_DIM   = 3;
  localparam int unsigned WIN_PIX   = WIN_DIM * WIN_DIM;
  localparam int unsigned WIN_W     = WIN_PIX * PIX_W;
  localparam int unsigned PIX_IDX_W = 4;

  // Window slot indices: p = r*3 + c, p0 is top-left.
  localparam logic [PIX_IDX_W-1:0] PIX_FIRST       = 4'd0;
  localparam logic [PIX_IDX_W-1:0] PIX_SHIFT_FIRST = 4'd2;
  localparam logic [PIX_IDX_W-1:0] PIX_LAST        = 4'd8;
  localparam logic [PIX_IDX_W-1:0] PIX_STEP_FULL   = 4'd1;
  localparam logic [PIX_IDX_W-1:0] PIX_STEP_SHIFT  = 4'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

  // Row offset of a window slot.
  function automatic logic [1:0] pix_row(input logic [PIX_IDX_W-1:0] p);
    case (p)
      4'd0, 4'd1, 4'd2: pix_row = 2'd0;
      4'd3, 4'd4, 4'd5: pix_row = 2'd1;
      4'd6, 4'd7, 4'd8: pix_row = 2'd2;
      default:          pix_row = 2'd0;
    endcase
  endfunction

  // Column offset of a window slot.
  function automatic logic [1:0] pix_col(input logic [PIX_IDX_W-1:0] p);
    case (p)
      4'd0, 4'd3, 4'd6: pix_col = 2'd0;
      4'd1, 4'd4, 4'd7: pix_col = 2'd1;
      4'd2, 4'd5, 4'd8: pix_col = 2'd2;
      default:          pix_col = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/window_addr_gen.sv
// Pixel address for window slot (r,c): base + (row+r)*width + (col+c), modulo 2^ADDR_W.
module window_addr_gen
  import sobel_pkg::*;
(
  input  logic [ADDR_W-1:0] base,
  input  logic [DIM_W-1:0]  width,
  input  logic [DIM_W-1:0]  row,
  input  logic [DIM_W-1:0]  col,
  input  logic [1:0]        r,
  input  logic [1:0]        c,
  output logic [ADDR_W-1:0] addr_c
);

  logic [DIM_X_W-1:0] row_x;
  logic [DIM_X_W-1:0] col_x;

  // Extend offsets one bit so row+r / col+c never wrap before the multiply.
  always_comb begin
    row_x  = DIM_X_W'(row) + DIM_X_W'(r);
    col_x  = DIM_X_W'(col) + DIM_X_W'(c);
    addr_c = base + ADDR_W'(row_x) * ADDR_W'(width) + ADDR_W'(col_x);
  end

endmodule

// File: rtl/window_fetch.sv
// Fetches the 3x3 Sobel neighbourhood from pixel memory, full window or one-column slide.
module window_fetch
  import sobel_pkg::*;
(
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start_9_read,
  input  logic              start_shift,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [DIM_W-1:0]  img_width,
  input  logic [DIM_W-1:0]  row,
  input  logic [DIM_W-1:0]  col,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [PIX_W-1:0]  mem_rdata,
  input  logic              mem_rvalid,
  output logic [WIN_W-1:0]  window,
  output logic              read_data_done,
  output logic              read_done,
  output logic              busy
);

  fetch_state_t state_q, state_d;

  logic                 mem_read_q, mem_read_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic [WIN_W-1:0]     win_q, win_d;
  logic                 rdd_q, rdd_d;
  logic                 rd_q, rd_d;
  logic                 busy_q, busy_d;
  logic [PIX_IDX_W-1:0] pix_q, pix_d;
  logic                 shift_mode_q, shift_mode_d;
  logic [ADDR_W-1:0]    base_q, base_d;
  logic [DIM_W-1:0]     width_q, width_d;
  logic [DIM_W-1:0]     row_q, row_d;
  logic [DIM_W-1:0]     col_q, col_d;

  logic                 start_c;
  logic                 capture_c;
  logic                 last_c;
  logic [PIX_IDX_W-1:0] pix_next_c;

  logic [ADDR_W-1:0]    ag_base_c;
  logic [DIM_W-1:0]     ag_width_c;
  logic [DIM_W-1:0]     ag_row_c;
  logic [DIM_W-1:0]     ag_col_c;
  logic [PIX_IDX_W-1:0] ag_pix_c;
  logic [1:0]           ag_r_c;
  logic [1:0]           ag_c_c;
  logic [ADDR_W-1:0]    ag_addr_c;

  assign start_c    = start_9_read | start_shift;
  assign capture_c  = (state_q == READ) && mem_read_q && mem_rvalid;
  assign last_c     = (pix_q == PIX_LAST);
  assign pix_next_c = pix_q + (shift_mode_q ? PIX_STEP_SHIFT : PIX_STEP_FULL);

  // Address source: live ports for the first pixel, latched geometry afterwards.
  always_comb begin
    ag_base_c  = base_q;
    ag_width_c = width_q;
    ag_row_c   = row_q;
    ag_col_c   = col_q;
    ag_pix_c   = pix_next_c;
    if (state_q == IDLE) begin
      ag_base_c  = base_addr;
      ag_width_c = img_width;
      ag_row_c   = row;
      ag_col_c   = col;
      ag_pix_c   = start_9_read ? PIX_FIRST : PIX_SHIFT_FIRST;
    end
    ag_r_c = pix_row(ag_pix_c);
    ag_c_c = pix_col(ag_pix_c);
  end

  window_addr_gen u_addr_gen (
    .base   (ag_base_c),
    .width  (ag_width_c),
    .row    (ag_row_c),
    .col    (ag_col_c),
    .r      (ag_r_c),
    .c      (ag_c_c),
    .addr_c (ag_addr_c)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!n_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_c) state_d = READ;
      READ:    if (capture_c && last_c) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values for the datapath and registered outputs.
  always_comb begin
    mem_read_d   = mem_read_q;
    mem_addr_d   = mem_addr_q;
    win_d        = win_q;
    rdd_d        = 1'b0;
    rd_d         = 1'b0;
    busy_d       = busy_q;
    pix_d        = pix_q;
    shift_mode_d = shift_mode_q;
    base_d       = base_q;
    width_d      = width_q;
    row_d        = row_q;
    col_d        = col_q;
    case (state_q)
      IDLE: begin
        if (start_c) begin
          base_d     = base_addr;
          width_d    = img_width;
          row_d      = row;
          col_d      = col;
          mem_read_d = 1'b1;
          mem_addr_d = ag_addr_c;
          busy_d     = 1'b1;
          if (start_9_read) begin
            pix_d        = PIX_FIRST;
            shift_mode_d = 1'b0;
          end else begin
            pix_d        = PIX_SHIFT_FIRST;
            shift_mode_d = 1'b1;
            for (int unsigned i = 0; i < WIN_DIM; i++) begin
              win_d[(i*WIN_DIM)*PIX_W +: PIX_W]     = win_q[(i*WIN_DIM+1)*PIX_W +: PIX_W];
              win_d[(i*WIN_DIM+1)*PIX_W +: PIX_W]   = win_q[(i*WIN_DIM+2)*PIX_W +: PIX_W];
            end
          end
        end
      end
      READ: begin
        if (capture_c) begin
          win_d[32'(pix_q)*PIX_W +: PIX_W] = mem_rdata;
          rdd_d = 1'b1;
          if (last_c) begin
            mem_read_d = 1'b0;
            rd_d       = 1'b1;
          end else begin
            pix_d      = pix_next_c;
            mem_addr_d = ag_addr_c;
          end
        end
      end
      DONE: begin
        busy_d = 1'b0;
      end
      default: begin
        mem_read_d = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      mem_read_q   <= 1'b0;
      mem_addr_q   <= '0;
      win_q        <= '0;
      rdd_q        <= 1'b0;
      rd_q         <= 1'b0;
      busy_q       <= 1'b0;
      pix_q        <= '0;
      shift_mode_q <= 1'b0;
      base_q       <= '0;
      width_q      <= '0;
      row_q        <= '0;
      col_q        <= '0;
    end else begin
      mem_read_q   <= mem_read_d;
      mem_addr_q   <= mem_addr_d;
      win_q        <= win_d;
      rdd_q        <= rdd_d;
      rd_q         <= rd_d;
      busy_q       <= busy_d;
      pix_q        <= pix_d;
      shift_mode_q <= shift_mode_d;
      base_q       <= base_d;
      width_q      <= width_d;
      row_q        <= row_d;
      col_q        <= col_d;
    end
  end

  assign mem_read       = mem_read_q;
  assign mem_addr       = mem_addr_q;
  assign window         = win_q;
  assign read_data_done = rdd_q;
  assign read_done      = rd_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_window_fetch.sv
// Self-checking bench for window_fetch with a wait-state memory model and window reference.
module tb_window_fetch;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        start_9_read;
  logic        start_shift;
  logic [19:0] base_addr;
  logic [9:0]  img_width;
  logic [9:0]  row;
  logic [9:0]  col;
  logic        mem_read;
  logic [19:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        mem_rvalid;
  logic [71:0] window;
  logic        read_data_done;
  logic        read_done;
  logic        busy;

  window_fetch dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .start_9_read   (start_9_read),
    .start_shift    (start_shift),
    .base_addr      (base_addr),
    .img_width      (img_width),
    .row            (row),
    .col            (col),
    .mem_read       (mem_read),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .mem_rvalid     (mem_rvalid),
    .window         (window),
    .read_data_done (read_data_done),
    .read_done      (read_done),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_shift;
    bit          both;
    logic [19:0] base;
    logic [9:0]  w;
    logic [9:0]  r;
    logic [9:0]  c;
    int          wt;
    int          poke;
    bit          poke_done;
    int          exp_lat;
  } fvec_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // memory model / monitor state
  int          mem_wait = 0;
  int          mcnt     = 0;
  int          stab_err = 0;
  int          rdd_cnt  = 0;
  int          rd_cnt   = 0;
  bit          force_rv = 1'b0;
  logic [7:0]  salt     = 8'h00;
  logic [19:0] hold_addr;
  logic [19:0] addr_log[$];
  logic [19:0] exp_addr[$];

  // reference window, slot p = r*3 + c
  logic [7:0]  pix[9];

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] mem_val(input logic [19:0] a);
    mem_val = a[7:0] ^ salt;
  endfunction

  function automatic logic [19:0] model_addr(input logic [19:0] b, input logic [9:0] w,
                                             input logic [9:0] r, input logic [9:0] c, input int p);
    longint a;
    a = longint'(b) + (longint'(r) + longint'(p / 3)) * longint'(w) + longint'(c) + longint'(p % 3);
    model_addr = 20'(a);
  endfunction

  function automatic logic [71:0] pack_win();
    logic [71:0] v;
    for (int p = 0; p < 9; p++) v[p*8 +: 8] = pix[p];
    pack_win = v;
  endfunction

  // One clock: sample on the falling edge, then act as memory for the next rising edge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (read_data_done === 1'b1) rdd_cnt++;
    if (read_done === 1'b1) rd_cnt++;
    if (force_rv) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 8'hAA;
      mcnt       = 0;
    end else if (mem_read === 1'b1) begin
      if (mcnt == 0) hold_addr = mem_addr;
      else if (mem_addr !== hold_addr) stab_err++;
      if (mcnt >= mem_wait) begin
        mem_rvalid = 1'b1;
        mem_rdata  = mem_val(mem_addr);
        addr_log.push_back(mem_addr);
        mcnt = 0;
      end else begin
        mem_rvalid = 1'b0;
        mcnt++;
      end
    end else begin
      mem_rvalid = 1'b0;
      mcnt       = 0;
    end
  endtask

  task automatic do_fetch(input fvec_t v, input string tag);
    int          t0;
    int          lat;
    int          npix;
    logic [19:0] a;
    addr_log.delete();
    exp_addr.delete();
    rdd_cnt = 0; rd_cnt = 0; stab_err = 0; mcnt = 0;
    mem_wait = v.wt;
    npix = v.is_shift ? 3 : 9;
    // reference: addresses from the geometry, window from the slide/refill rule
    if (v.is_shift) begin
      for (int r = 0; r < 3; r++) begin
        pix[r*3]   = pix[r*3+1];
        pix[r*3+1] = pix[r*3+2];
        a = model_addr(v.base, v.w, v.r, v.c, r*3+2);
        exp_addr.push_back(a);
        pix[r*3+2] = mem_val(a);
      end
    end else begin
      for (int p = 0; p < 9; p++) begin
        a = model_addr(v.base, v.w, v.r, v.c, p);
        exp_addr.push_back(a);
        pix[p] = mem_val(a);
      end
    end
    base_addr = v.base; img_width = v.w; row = v.r; col = v.c;
    start_9_read = !v.is_shift || v.both;
    start_shift  = v.is_shift || v.both;
    t0 = cyc;
    tick();
    start_9_read = 1'b0; start_shift = 1'b0;
    while (read_done !== 1'b1 && (cyc - t0) < 400) begin
      if (v.poke != 0 && (cyc - t0) == v.poke) begin
        start_9_read = 1'b1; start_shift = 1'b1;
        row = v.r + 10'd1; col = v.c + 10'd3;
      end else begin
        start_9_read = 1'b0; start_shift = 1'b0;
      end
      tick();
    end
    lat = cyc - t0;
    chk({tag, "_done_seen"}, 72'(read_done === 1'b1), 72'd1);
    chk({tag, "_latency"}, 72'(lat), 72'(v.exp_lat));
    start_9_read = v.poke_done; start_shift = 1'b0;
    row = v.r + 10'd2;
    tick();
    start_9_read = 1'b0;
    chk({tag, "_busy_drop"}, 72'(busy), 72'd0);
    chk({tag, "_window"}, window, pack_win());
    for (int k = 0; k < 3; k++) tick();
    chk({tag, "_no_restart"}, 72'(mem_read | busy), 72'd0);
    chk({tag, "_rd_once"}, 72'(rd_cnt), 72'd1);
    chk({tag, "_rdd_count"}, 72'(rdd_cnt), 72'(npix));
    chk({tag, "_addr_count"}, 72'(addr_log.size()), 72'(npix));
    for (int i = 0; i < npix && i < addr_log.size(); i++)
      chk($sformatf("%s_addr%0d", tag, i), 72'(addr_log[i]), 72'(exp_addr[i]));
    if (v.wt > 0) chk({tag, "_addr_stable"}, 72'(stab_err), 72'd0);
  endtask

  initial begin
    fvec_t tbl[8];
    fvec_t v;
    int    guard;

    tbl[0] = '{0, 0, 20'h00100, 10'd640,  10'd2,    10'd5,    0, 0, 0, 10};
    tbl[1] = '{1, 0, 20'h00100, 10'd640,  10'd2,    10'd6,    0, 0, 0, 4};
    tbl[2] = '{0, 0, 20'h00100, 10'd640,  10'd2,    10'd5,    2, 0, 0, 28};
    tbl[3] = '{1, 0, 20'h00100, 10'd640,  10'd2,    10'd7,    2, 0, 0, 10};
    tbl[4] = '{0, 0, 20'h00100, 10'd640,  10'd2,    10'd5,    1, 5, 1, 19};
    tbl[5] = '{0, 1, 20'h00200, 10'd320,  10'd7,    10'd9,    0, 0, 0, 10};
    tbl[6] = '{0, 0, 20'hFFFF0, 10'd1023, 10'd1020, 10'd1020, 0, 0, 0, 10};
    tbl[7] = '{1, 0, 20'hFFFF0, 10'd1023, 10'd1020, 10'd1021, 0, 0, 0, 4};

    n_rst = 1'b0; start_9_read = 1'b0; start_shift = 1'b0;
    base_addr = '0; img_width = '0; row = '0; col = '0;
    mem_rdata = '0; mem_rvalid = 1'b0;
    for (int p = 0; p < 9; p++) pix[p] = 8'h00;

    // reset values
    repeat (3) tick();
    chk("rst_mem_read", 72'(mem_read), 72'd0);
    chk("rst_mem_addr", 72'(mem_addr), 72'd0);
    chk("rst_window", window, 72'd0);
    chk("rst_rdd", 72'(read_data_done), 72'd0);
    chk("rst_read_done", 72'(read_done), 72'd0);
    chk("rst_busy", 72'(busy), 72'd0);
    n_rst = 1'b1;
    tick();

    // directed vectors
    for (int i = 0; i < 8; i++) do_fetch(tbl[i], $sformatf("vec%0d", i));

    // reset mid-fetch with a read outstanding, then a late strobe
    salt = 8'h00; mem_wait = 2; rdd_cnt = 0; mcnt = 0; addr_log.delete();
    base_addr = 20'h00100; img_width = 10'd640; row = 10'd2; col = 10'd5;
    start_9_read = 1'b1;
    tick();
    start_9_read = 1'b0;
    guard = 0;
    while (rdd_cnt < 4 && guard < 100) begin tick(); guard++; end
    chk("midrst_reach_pix4", 72'(rdd_cnt), 72'd4);
    n_rst = 1'b0; force_rv = 1'b1;
    tick();
    chk("midrst_mem_read", 72'(mem_read), 72'd0);
    chk("midrst_window", window, 72'd0);
    chk("midrst_busy", 72'(busy), 72'd0);
    n_rst = 1'b1;
    tick();
    tick();
    chk("late_rvalid_window", window, 72'd0);
    chk("late_rvalid_rdd", 72'(read_data_done), 72'd0);
    chk("late_rvalid_mem_read", 72'(mem_read), 72'd0);
    force_rv = 1'b0;
    tick();
    for (int p = 0; p < 9; p++) pix[p] = 8'h00;
    do_fetch(tbl[0], "after_rst");

    // randomized operations against the reference
    for (int i = 0; i < 30; i++) begin
      v.is_shift  = ($urandom_range(0, 2) == 0);
      v.both      = !v.is_shift && ($urandom_range(0, 3) == 0);
      v.base      = 20'($urandom);
      v.w         = 10'($urandom_range(1, 1023));
      v.r         = 10'($urandom);
      v.c         = 10'($urandom);
      v.wt        = $urandom_range(0, 3);
      v.poke      = 0;
      v.poke_done = $urandom_range(0, 1) == 1;
      v.exp_lat   = (v.is_shift ? 4 : 10) + (v.is_shift ? 3 : 9) * v.wt;
      salt        = 8'($urandom);
      do_fetch(v, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
